spi_config_slave: RTL and testbench
===================================

Name: spi_config_slave

Overview:
- Second-generation SPI configuration and readback slave for the spiking-network core.
- Oversamples SPI mode 0 (CPOL=0, CPHA=0) entirely in the system clock domain, so the core sees no sclk-clocked logic.
- Field widths, neuron counts and spike readback length are fully parametrised.
- Adds sticky spike capture, a status/error register, range checking, and clean abort on cs deassertion.
- Sits between the external host SPI pins and the neuron/synapse configuration ports of the network.

Parameters:
WIDTH, 16, bit width of neuron parameters and synapse weight (8..32, multiple of 8)
N_INPUT, 4, number of presynaptic (input) neurons; syn_src range 0..N_INPUT-1
N_OUTPUT, 3, number of output neurons; spike readback bit count
FIELD_BYTES, WIDTH/8, derived localparam: bytes per WIDTH-bit field, big-endian

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock, asynchronous to clk; maximum frequency clk/8
cs  in  1  SPI chip select, active low, asynchronous
mosi  in  1  SPI data in, sampled on sclk rising edge
miso  out  1  SPI data out, changes after sclk falling edge, MSB first
param_threshold  out  WIDTH  neuron threshold
param_leak  out  WIDTH  leak value
param_refr  out  WIDTH  refractory period
param_vmax  out  WIDTH  signed membrane upper clamp
param_vmin  out  WIDTH  signed membrane lower clamp
syn_src  out  $clog2(N_INPUT)  synapse source index
syn_dst  out  $clog2(N_OUTPUT)  synapse destination index
syn_weight  out  WIDTH  signed synapse weight
load_params  out  1  one-clk pulse: parameter outputs valid
update_synapse  out  1  one-clk pulse: synapse outputs valid
net_reset  out  1  one-clk pulse: reset network state
spike_in  in  N_OUTPUT  per-clk output spike vector from the core

Behaviour:
- Reset values: all outputs 0, miso 0, status 0, sticky spike register 0, FSM in IDLE.
- Input synchronisation: sclk, cs and mosi each pass through a 2-flop synchroniser. sclk rise/fall events come from a registered edge detect.
- A byte completes on the 8th synchronised rising edge after cs falls, or after the previous byte completes.
- FSM states and transitions:
  - IDLE: first byte is the command. 0x01 goes to PARAMS. 0x02 goes to SYNAPSE. 0x03 pulses net_reset and returns to IDLE. 0x04 goes to RD_SPIKE. 0x05 goes to RD_STATUS. 0x06 clears status and returns to IDLE. Any other value sets status[0] (cmd_err) and goes to DRAIN.
  - PARAMS: collect 5*FIELD_BYTES bytes into the staging buffer. After the last byte, all five outputs update in the same clk and load_params pulses. Return to IDLE.
  - SYNAPSE: collect 1 src byte, 1 dst byte and FIELD_BYTES weight bytes. If src>=N_INPUT or dst>=N_OUTPUT, set status[1] (range_err), emit no pulse and leave outputs unchanged. Otherwise update outputs and pulse update_synapse. Return to IDLE.
  - RD_SPIKE: on command completion, snapshot the sticky register into the tx buffer and clear it in the same clk. Spikes arriving that clk go into the new sticky value and are not lost. Shift out ceil(N_OUTPUT/8) bytes, MSB first, with bit0 = output 0 and pad bits 0. Return to IDLE.
  - RD_STATUS: shift out 1 byte, {5'b0, crc_err, range_err, cmd_err}. Return to IDLE.
  - DRAIN: ignore bytes until cs rises.
- Sticky spike register: sticky |= spike_in every clk.
- MISO: the first tx bit is driven immediately at command completion. Subsequent bits update on each synchronised sclk falling edge. miso is 0 when not transmitting.
- Latency: pulse outputs assert exactly 3 clk after the sclk pin rising edge of the final payload bit, with ±1 clk for synchroniser phase. Each pulse is high for exactly 1 clk.
- Extra bytes after a completed packet while cs stays low are parsed as a new command.
- cs rise mid-packet: abort, discard the staging buffer and partial byte, emit no pulse, leave outputs unchanged, return to IDLE. Status is not affected.
- reset_n assertion at any time forces all reset values immediately, including during a transfer.

Optional Feature:
SPI_CFG_CRC_EN
- Defined:
  - PARAMS and SYNAPSE packets carry one extra trailing byte: CRC-8, polynomial 0x07, init 0x00, computed over the command byte and the payload.
  - On mismatch: set status[2] (crc_err), emit no pulse, leave outputs unchanged.
  - CRC is computed incrementally per byte; no extra clk of latency is added.
- Undefined: no CRC byte, status[2] reads 0, and the CRC logic is absent.

Decomposition:
- Package spi_cfg_pkg contains:
  - command enum: CMD_PARAMS=0x01, CMD_SYNAPSE=0x02, CMD_NET_RESET=0x03, CMD_RD_SPIKE=0x04, CMD_RD_STATUS=0x05, CMD_CLR_STATUS=0x06
  - FSM state enum
  - status bit index constants
  - CRC-8 polynomial constant and a crc8_byte function
- Sub-module spi_byte_shifter handles synchronisers, edge detect, the rx shift register with a byte_valid strobe, and the tx shift register with a load strobe.
- Top level holds the FSM, staging buffer, sticky register and status.

Test Plan:
- Params write: 0x01 then 00 10 00 01 00 03 00 64 FF 9C → threshold=0x0010, leak=1, refr=3, vmax=100, vmin=-100; load_params high for exactly 1 clk.
- Synapse write: 0x02 02 01 FF F6 → syn_src=2, syn_dst=1, syn_weight=-10, one update_synapse pulse. Then 0x02 04 01 00 05 → no pulse, outputs unchanged, 0x05 readback returns 0x02.
- Spike readback: pulse spike_in=3'b101 for one clk, then 0x04 → miso byte 0x05. An immediately repeated 0x04 with no spikes → 0x00.
- Abort: 0x01 plus 4 payload bytes, then cs high → no load_params, outputs retain prior values. Next 0x03 → one net_reset pulse.
- Error and clear: 0x7E → 0x05 returns 0x01. 0x06, then 0x05 returns 0x00.
- Reset and CRC: reset_n low mid-params packet → all outputs 0, FSM in IDLE. With SPI_CFG_CRC_EN, a synapse packet with wrong CRC → no pulse, status 0x04.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared commands, FSM states, status bit indices and CRC-8 helper
package spi_cfg_pkg;

  typedef enum logic [7:0] {
    CMD_PARAMS     = 8'h01,
    CMD_SYNAPSE    = 8'h02,
    CMD_NET_RESET  = 8'h03,
    CMD_RD_SPIKE   = 8'h04,
    CMD_RD_STATUS  = 8'h05,
    CMD_CLR_STATUS = 8'h06
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PARAMS,
    ST_SYNAPSE,
    ST_RD_SPIKE,
    ST_RD_STATUS,
    ST_DRAIN
  } state_e;

  localparam int STAT_CMD_ERR   = 0;
  localparam int STAT_RANGE_ERR = 1;
  localparam int STAT_CRC_ERR   = 2;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // MSB-first CRC-8 update over one byte, no reflection
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/spi_config_slave_if.sv
// rtl/spi_config_slave_if.sv - SPI pin bundle between host and config slave
interface spi_config_slave_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport slave  (input sclk, cs, mosi, output miso);
  modport master (output sclk, cs, mosi, input miso);
endinterface

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - SPI mode 0 oversampler: synchronisers, edge detect, rx/tx byte shifters
module spi_byte_shifter (
  input  logic              clk,
  input  logic              reset_n,
  spi_config_slave_if.slave spi,
  output logic              cs_act,
  output logic              byte_valid,
  output logic [7:0]        rx_byte,
  input  logic              tx_load,
  input  logic [7:0]        tx_data
);

  logic [2:0] sclk_q;
  logic [1:0] cs_q;
  logic [1:0] mosi_q;
  logic [6:0] rx_sr;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sr;
  logic       rise;
  logic       fall;

  assign rise       = sclk_q[1] & ~sclk_q[2];
  assign fall       = ~sclk_q[1] & sclk_q[2];
  assign cs_act     = ~cs_q[1];
  assign rx_byte    = {rx_sr, mosi_q[1]};
  assign byte_valid = cs_act & rise & (bit_cnt == 3'd7);
  assign spi.miso   = tx_sr[7];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q  <= '0;
      cs_q    <= 2'b11;
      mosi_q  <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi.sclk};
      cs_q   <= {cs_q[0], spi.cs};
      mosi_q <= {mosi_q[0], spi.mosi};
      if (!cs_act) begin
        rx_sr   <= '0;
        bit_cnt <= '0;
        tx_sr   <= '0;
      end else begin
        if (rise) begin
          rx_sr   <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        // The fall right after a byte boundary must keep the freshly loaded MSB on the pin
        if (tx_load) tx_sr <= tx_data;
        else if (fall && bit_cnt != 3'd0) tx_sr <= {tx_sr[6:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_config_slave.sv
// rtl/spi_config_slave.sv - config/readback slave top: FSM, staging, sticky spikes, status; SPI_CFG_CRC_EN adds trailing CRC-8
module spi_config_slave
  import spi_cfg_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int N_INPUT     = 4,
  parameter  int N_OUTPUT    = 3,
  localparam int FIELD_BYTES = WIDTH / 8,
  localparam int SRC_W       = (N_INPUT > 1) ? $clog2(N_INPUT) : 1,
  localparam int DST_W       = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_config_slave_if.slave    spi,
  output logic [WIDTH-1:0]     param_threshold,
  output logic [WIDTH-1:0]     param_leak,
  output logic [WIDTH-1:0]     param_refr,
  output logic [WIDTH-1:0]     param_vmax,
  output logic [WIDTH-1:0]     param_vmin,
  output logic [SRC_W-1:0]     syn_src,
  output logic [DST_W-1:0]     syn_dst,
  output logic [WIDTH-1:0]     syn_weight,
  output logic                 load_params,
  output logic                 update_synapse,
  output logic                 net_reset,
  input  logic [N_OUTPUT-1:0]  spike_in
);

`ifdef SPI_CFG_CRC_EN
  localparam int CRC_BYTES = 1;
`else
  localparam int CRC_BYTES = 0;
`endif
  localparam int PB       = 5 * WIDTH;
  localparam int SYN_BITS = WIDTH + 16;
  localparam int STG_W    = PB - 8 + 8 * CRC_BYTES;
  localparam int SPK_W    = ((N_OUTPUT + 7) / 8) * 8;
  localparam logic [7:0] PAR_LAST = 8'(5 * FIELD_BYTES + CRC_BYTES - 1);
  localparam logic [7:0] SYN_LAST = 8'(2 + FIELD_BYTES + CRC_BYTES - 1);
  localparam logic [7:0] SPK_LAST = 8'(SPK_W / 8 - 1);

  state_e               state, state_next;
  logic                 cs_act, byte_valid, tx_load;
  logic [7:0]           rx_byte, tx_data, byte_cnt;
  logic [STG_W-1:0]     stage;
  logic [PB-1:0]        dvec;
  logic [SPK_W-1:0]     spk_snap, spk_buf;
  logic [N_OUTPUT-1:0]  sticky;
  logic [2:0]           status, status_next;
  logic [7:0]           src_b, dst_b;
  logic                 crc_ok, in_range;
  logic                 do_load, do_syn, do_reset, do_snap;

  spi_byte_shifter u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi        (spi),
    .cs_act     (cs_act),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte),
    .tx_load    (tx_load),
    .tx_data    (tx_data)
  );

  // dvec is the whole payload at the moment its final byte (data or CRC) arrives
`ifdef SPI_CFG_CRC_EN
  logic [7:0] crc;
  assign dvec   = stage;
  assign crc_ok = (rx_byte == crc);
`else
  assign dvec   = {stage, rx_byte};
  assign crc_ok = 1'b1;
`endif

  assign src_b    = dvec[SYN_BITS-1 -: 8];
  assign dst_b    = dvec[SYN_BITS-9 -: 8];
  assign in_range = (32'(src_b) < N_INPUT) && (32'(dst_b) < N_OUTPUT);

  always_comb begin
    spk_snap = '0;
    spk_snap[N_OUTPUT-1:0] = sticky;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    status_next = status;
    tx_load     = 1'b0;
    tx_data     = 8'h00;
    do_load     = 1'b0;
    do_syn      = 1'b0;
    do_reset    = 1'b0;
    do_snap     = 1'b0;
    if (!cs_act) begin
      state_next = ST_IDLE;
    end else if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          case (rx_byte)
            CMD_PARAMS:     state_next = ST_PARAMS;
            CMD_SYNAPSE:    state_next = ST_SYNAPSE;
            CMD_NET_RESET:  do_reset = 1'b1;
            CMD_RD_SPIKE: begin
              state_next = ST_RD_SPIKE;
              do_snap    = 1'b1;
              tx_load    = 1'b1;
              tx_data    = spk_snap[SPK_W-1 -: 8];
            end
            CMD_RD_STATUS: begin
              state_next = ST_RD_STATUS;
              tx_load    = 1'b1;
              tx_data    = {5'b0, status};
            end
            CMD_CLR_STATUS: status_next = '0;
            default: begin
              status_next[STAT_CMD_ERR] = 1'b1;
              state_next = ST_DRAIN;
            end
          endcase
        end
        ST_PARAMS: if (byte_cnt == PAR_LAST) begin
          state_next = ST_IDLE;
          do_load    = crc_ok;
          if (!crc_ok) status_next[STAT_CRC_ERR] = 1'b1;
        end
        ST_SYNAPSE: if (byte_cnt == SYN_LAST) begin
          state_next = ST_IDLE;
          do_syn     = crc_ok && in_range;
          if (!crc_ok)   status_next[STAT_CRC_ERR]   = 1'b1;
          if (!in_range) status_next[STAT_RANGE_ERR] = 1'b1;
        end
        ST_RD_SPIKE: begin
          // Loading zero after the last byte parks miso low
          tx_load = 1'b1;
          if (byte_cnt == SPK_LAST) state_next = ST_IDLE;
          else                      tx_data = spk_buf[SPK_W-1 -: 8];
        end
        ST_RD_STATUS: begin
          tx_load    = 1'b1;
          state_next = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      param_threshold <= '0;
      param_leak      <= '0;
      param_refr      <= '0;
      param_vmax      <= '0;
      param_vmin      <= '0;
      syn_src         <= '0;
      syn_dst         <= '0;
      syn_weight      <= '0;
      load_params     <= 1'b0;
      update_synapse  <= 1'b0;
      net_reset       <= 1'b0;
      status          <= '0;
      sticky          <= '0;
      stage           <= '0;
      byte_cnt        <= '0;
      spk_buf         <= '0;
`ifdef SPI_CFG_CRC_EN
      crc             <= '0;
`endif
    end else begin
      load_params    <= do_load;
      update_synapse <= do_syn;
      net_reset      <= do_reset;
      status         <= status_next;
      sticky         <= do_snap ? spike_in : (sticky | spike_in);
      if (!cs_act) begin
        byte_cnt <= '0;
        stage    <= '0;
      end else if (byte_valid) begin
        if (state == ST_IDLE) begin
          byte_cnt <= '0;
          stage    <= '0;
          spk_buf  <= spk_snap << 8;
`ifdef SPI_CFG_CRC_EN
          crc      <= crc8_byte(8'h00, rx_byte);
`endif
        end else begin
          byte_cnt <= byte_cnt + 8'd1;
          stage    <= {stage[STG_W-9:0], rx_byte};
          spk_buf  <= spk_buf << 8;
`ifdef SPI_CFG_CRC_EN
          crc      <= crc8_byte(crc, rx_byte);
`endif
        end
      end
      if (do_load) begin
        param_threshold <= dvec[PB-1 -: WIDTH];
        param_leak      <= dvec[4*WIDTH-1 -: WIDTH];
        param_refr      <= dvec[3*WIDTH-1 -: WIDTH];
        param_vmax      <= dvec[2*WIDTH-1 -: WIDTH];
        param_vmin      <= dvec[WIDTH-1:0];
      end
      if (do_syn) begin
        syn_src    <= src_b[SRC_W-1:0];
        syn_dst    <= dst_b[DST_W-1:0];
        syn_weight <= dvec[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_spi_config_slave.sv
// tb/tb_spi_config_slave.sv - directed and randomized bench for spi_config_slave against a packet-level model
module tb_spi_config_slave;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_config_slave_if spi_if ();

  logic [W-1:0] param_threshold, param_leak, param_refr, param_vmax, param_vmin, syn_weight;
  logic [1:0]   syn_src, syn_dst;
  logic         load_params, update_synapse, net_reset;
  logic [2:0]   spike_in = 3'b000;

  spi_config_slave dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .spi             (spi_if),
    .param_threshold (param_threshold),
    .param_leak      (param_leak),
    .param_refr      (param_refr),
    .param_vmax      (param_vmax),
    .param_vmin      (param_vmin),
    .syn_src         (syn_src),
    .syn_dst         (syn_dst),
    .syn_weight      (syn_weight),
    .load_params     (load_params),
    .update_synapse  (update_synapse),
    .net_reset       (net_reset),
    .spike_in        (spike_in)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise = 0;
  int lp_cnt = 0, lp_hi = 0, lp_at = 0, us_cnt = 0, us_hi = 0, us_at = 0, nr_cnt = 0, nr_hi = 0;
  int s_lp, s_lph, s_us, s_ush, s_nr, s_nrh;
  logic lp_q = 1'b0, us_q = 1'b0, nr_q = 1'b0;

  logic [W-1:0] m_thr, m_leak, m_refr, m_vmax, m_vmin, m_w;
  int           m_src, m_dst;
  logic [2:0]   m_status, m_sticky;
  logic [7:0]   tx_q[$];
  logic [7:0]   rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_params)    begin lp_hi++; if (!lp_q) begin lp_cnt++; lp_at = cyc; end end
    if (update_synapse) begin us_hi++; if (!us_q) begin us_cnt++; us_at = cyc; end end
    if (net_reset)      begin nr_hi++; if (!nr_q) nr_cnt++; end
    lp_q = load_params;
    us_q = update_synapse;
    nr_q = net_reset;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: run did not complete (errors so far %0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_thr"},  64'(param_threshold), 64'(m_thr));
    check({tag, "_leak"}, 64'(param_leak),      64'(m_leak));
    check({tag, "_refr"}, 64'(param_refr),      64'(m_refr));
    check({tag, "_vmax"}, 64'(param_vmax),      64'(m_vmax));
    check({tag, "_vmin"}, 64'(param_vmin),      64'(m_vmin));
    check({tag, "_src"},  64'(syn_src),         64'(m_src));
    check({tag, "_dst"},  64'(syn_dst),         64'(m_dst));
    check({tag, "_w"},    64'(syn_weight),      64'(m_w));
    check({tag, "_miso"}, 64'(spi_if.miso),     64'd0);
  endtask

  task automatic snap();
    s_lp = lp_cnt; s_lph = lp_hi; s_us = us_cnt; s_ush = us_hi; s_nr = nr_cnt; s_nrh = nr_hi;
  endtask

  task automatic check_pulses(input string tag, input int nl, input int ns, input int nn);
    check({tag, "_lp_n"}, 64'(lp_cnt - s_lp), 64'(nl));
    check({tag, "_lp_w"}, 64'(lp_hi - s_lph), 64'(nl));
    check({tag, "_us_n"}, 64'(us_cnt - s_us), 64'(ns));
    check({tag, "_us_w"}, 64'(us_hi - s_ush), 64'(ns));
    check({tag, "_nr_n"}, 64'(nr_cnt - s_nr), 64'(nn));
    check({tag, "_nr_w"}, 64'(nr_hi - s_nrh), 64'(nn));
  endtask

  // Augmented long division of the whole message by x^8+x^2+x+1
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    int unsigned rem;
    int nb;
    int b;
    rem = 0;
    nb = msg.size() * 8;
    for (int i = 0; i < nb + 8; i++) begin
      b = (i < nb) ? int'(msg[i / 8][7 - (i % 8)]) : 0;
      rem = (rem << 1) | b;
      if ((rem & 32'h100) != 0) rem = rem ^ 32'h107;
    end
    return rem[7:0];
  endfunction

  task automatic add_crc();
`ifdef SPI_CFG_CRC_EN
    tx_q.push_back(model_crc(tx_q));
`endif
  endtask

  task automatic cs_low();
    spi_if.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    spi_if.cs = 1'b1;
    spi_if.mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_if.mosi = b[i];
      repeat (4) @(negedge clk);
      spi_if.sclk = 1'b1;
      last_rise = cyc;
      r[i] = spi_if.miso;
      repeat (4) @(negedge clk);
      spi_if.sclk = 1'b0;
    end
  endtask

  task automatic xfer();
    logic [7:0] r;
    rx_q.delete();
    cs_low();
    foreach (tx_q[k]) begin
      send_byte(tx_q[k], r);
      rx_q.push_back(r);
    end
    cs_high();
  endtask

  task automatic push_w(input logic [W-1:0] v);
    tx_q.push_back(v[15:8]);
    tx_q.push_back(v[7:0]);
  endtask

  task automatic send_params(input logic [W-1:0] t, l, rf, vx, vn);
    tx_q.delete();
    tx_q.push_back(8'h01);
    push_w(t); push_w(l); push_w(rf); push_w(vx); push_w(vn);
    add_crc();
    snap();
    xfer();
    m_thr = t; m_leak = l; m_refr = rf; m_vmax = vx; m_vmin = vn;
    check_pulses("params", 1, 0, 0);
    check("params_latency", 64'((lp_at - last_rise) >= 2 && (lp_at - last_rise) <= 4), 64'd1);
    check_outputs("params");
  endtask

  task automatic send_syn(input int src, input int dst, input logic [W-1:0] w);
    logic ok;
    ok = (src < 4) && (dst < 3);
    tx_q.delete();
    tx_q.push_back(8'h02);
    tx_q.push_back(8'(src));
    tx_q.push_back(8'(dst));
    push_w(w);
    add_crc();
    snap();
    xfer();
    if (ok) begin
      m_src = src; m_dst = dst; m_w = w;
      check("syn_latency", 64'((us_at - last_rise) >= 2 && (us_at - last_rise) <= 4), 64'd1);
    end else begin
      m_status[1] = 1'b1;
    end
    check_pulses("syn", 0, ok ? 1 : 0, 0);
    check_outputs("syn");
  endtask

  task automatic read_status();
    tx_q = {8'h05, 8'h00};
    xfer();
    check("status_rd", 64'(rx_q[1]), 64'({5'b0, m_status}));
    check("status_miso_idle", 64'(spi_if.miso), 64'd0);
  endtask

  task automatic read_spike();
    tx_q = {8'h04, 8'h00};
    xfer();
    check("spike_rd", 64'(rx_q[1]), 64'({5'b0, m_sticky}));
    m_sticky = 3'b000;
  endtask

  task automatic pulse_spikes(input logic [2:0] v);
    @(negedge clk) spike_in = v;
    @(negedge clk) spike_in = 3'b000;
    m_sticky = m_sticky | v;
  endtask

  task automatic simple_cmds(input string tag, input int nn);
    snap();
    xfer();
    check_pulses(tag, 0, 0, nn);
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_thr = '0; m_leak = '0; m_refr = '0; m_vmax = '0; m_vmin = '0;
    m_src = 0; m_dst = 0; m_w = '0; m_status = '0; m_sticky = '0;
  endtask

  initial begin
    logic [7:0] r;
    int op;
    spi_if.sclk = 1'b0;
    spi_if.cs   = 1'b1;
    spi_if.mosi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_lp", 64'(load_params), 64'd0);
    check("reset_us", 64'(update_synapse), 64'd0);
    check("reset_nr", 64'(net_reset), 64'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    read_status();

    send_params(16'h0010, 16'h0001, 16'h0003, 16'h0064, 16'hFF9C);
    send_syn(2, 1, 16'hFFF6);
    send_syn(4, 1, 16'h0005);
    read_status();

    pulse_spikes(3'b101);
    read_spike();
    read_spike();

    tx_q = {8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    simple_cmds("abort", 0);
    tx_q = {8'h03};
    simple_cmds("netrst", 1);
    tx_q = {8'h03, 8'h03};
    simple_cmds("back2back", 2);

    tx_q = {8'h06};
    simple_cmds("clr", 0);
    m_status = '0;
    tx_q = {8'h7E, 8'h03, 8'h01};
    simple_cmds("drain", 0);
    m_status[0] = 1'b1;
    read_status();
    tx_q = {8'h06};
    simple_cmds("clr2", 0);
    m_status = '0;
    read_status();

    for (int it = 0; it < 16; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: send_params(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        1: send_syn($urandom_range(0, 5), $urandom_range(0, 4), 16'($urandom));
        2: begin
          repeat ($urandom_range(1, 3)) pulse_spikes(3'($urandom));
          read_spike();
        end
        default: read_status();
      endcase
    end

`ifdef SPI_CFG_CRC_EN
    tx_q = {8'h06};
    simple_cmds("crc_clr", 0);
    m_status = '0;
    tx_q = {8'h02, 8'h01, 8'h01, 8'h00, 8'h05};
    tx_q.push_back(model_crc(tx_q) ^ 8'h5A);
    simple_cmds("crc_bad", 0);
    m_status[2] = 1'b1;
    read_status();
`endif

    pulse_spikes(3'b011);
    cs_low();
    send_byte(8'h01, r);
    send_byte(8'hAA, r);
    send_byte(8'hBB, r);
    send_byte(8'hCC, r);
    @(negedge clk) reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    check("midreset_lp", 64'(load_params), 64'd0);
    repeat (3) @(negedge clk);
    spi_if.cs = 1'b1;
    spi_if.mosi = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    read_status();
    read_spike();
    send_params(16'h1234, 16'h0002, 16'h0007, 16'h0100, 16'hFF00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
